// File: rtl/hyperbus_cfg_init.sv
// hyperbus_cfg_init: replays a register-write table into the HyperBus controller after reset or on start_i,
// with optional masked readback verify and retries, then hands the register port to the system bus.
package hyperbus_cfg_init_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;
    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

module hyperbus_cfg_init #(
    parameter int unsigned RegAddrWidth = 32,
    parameter int unsigned RegDataWidth = 32,
    parameter type reg_req_t = hyperbus_cfg_init_pkg::reg_req_t,
    parameter type reg_rsp_t = hyperbus_cfg_init_pkg::reg_rsp_t,
    parameter int unsigned NumEntries = 1,
    parameter logic [NumEntries-1:0][RegAddrWidth-1:0] InitAddr = '0,
    parameter logic [NumEntries-1:0][RegDataWidth-1:0] InitData = '0,
    parameter logic [NumEntries-1:0][RegDataWidth-1:0] VerifyMask = '0,
    parameter int unsigned MaxRetries = 2,
    localparam int unsigned IdxW = NumEntries > 1 ? $clog2(NumEntries) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  reg_req_t        sys_reg_req_i,
    output reg_rsp_t        sys_reg_rsp_o,
    output reg_req_t        hyp_reg_req_o,
    input  reg_rsp_t        hyp_reg_rsp_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            error_o,
    output logic [IdxW-1:0] err_idx_o
);
    localparam int unsigned RW = MaxRetries > 0 ? $clog2(MaxRetries + 1) : 1;

    typedef enum logic [2:0] {RESET, WRITE, READ, PASS, ERROR} state_e;

    state_e                  state_q;
    logic [IdxW-1:0]         idx_q, err_idx_q;
    logic [RW-1:0]           retry_q;
    logic                    pend_q, done_q, error_q, busy_q;
    logic [RegAddrWidth-1:0] e_addr;
    logic [RegDataWidth-1:0] e_data, e_mask;
    logic                    thru, hs, last, match, take, wr;

    assign thru  = state_q == PASS || state_q == ERROR;
    assign wr    = state_q == WRITE;
    assign hs    = hyp_reg_rsp_i.ready;
    assign last  = idx_q == IdxW'(NumEntries - 1);
    assign match = ((hyp_reg_rsp_i.rdata ^ e_data) & e_mask) == '0;
    // Takeover waits for the bus to be idle or for the forwarded access to finish.
    assign take  = thru && (pend_q || start_i) && (!sys_reg_req_i.valid || hs);

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign error_o   = error_q;
    assign err_idx_o = err_idx_q;

    always_comb begin
        e_addr = '0;
        e_data = '0;
        e_mask = '0;
        for (int i = 0; i < NumEntries; i++) begin
            if (idx_q == IdxW'(i)) begin
                e_addr = InitAddr[i];
                e_data = InitData[i];
                e_mask = VerifyMask[i];
            end
        end
        hyp_reg_req_o = '0;
        sys_reg_rsp_o = '0;
        if (thru) begin
            hyp_reg_req_o = sys_reg_req_i;
            sys_reg_rsp_o = hyp_reg_rsp_i;
        end else if (wr || state_q == READ) begin
            hyp_reg_req_o.valid = 1'b1;
            hyp_reg_req_o.write = wr;
            hyp_reg_req_o.addr  = e_addr;
            hyp_reg_req_o.wdata = wr ? e_data : '0;
            hyp_reg_req_o.wstrb = wr ? '1 : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= RESET;
            idx_q     <= '0;
            retry_q   <= '0;
            pend_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                RESET: begin
                    state_q <= WRITE;
                    busy_q  <= 1'b1;
                end
                WRITE: if (hs) begin
                    if (hyp_reg_rsp_i.error) begin
                        state_q   <= ERROR;
                        err_idx_q <= idx_q;
                        error_q   <= 1'b1;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                    end else if (e_mask != '0) begin
                        state_q <= READ;
                    end else if (last) begin
                        state_q <= PASS;
                        retry_q <= '0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q   <= idx_q + IdxW'(1);
                        retry_q <= '0;
                    end
                end
                READ: if (hs) begin
                    if (!hyp_reg_rsp_i.error && match) begin
                        retry_q <= '0;
                        state_q <= last ? PASS : WRITE;
                        idx_q   <= last ? idx_q : idx_q + IdxW'(1);
                        done_q  <= last;
                        busy_q  <= !last;
                    end else if (!hyp_reg_rsp_i.error && retry_q < RW'(MaxRetries)) begin
                        retry_q <= retry_q + RW'(1);
                        state_q <= WRITE;
                    end else begin
                        state_q   <= ERROR;
                        err_idx_q <= idx_q;
                        error_q   <= 1'b1;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                    end
                end
                default: begin
                    if (take) begin
                        state_q   <= WRITE;
                        idx_q     <= '0;
                        retry_q   <= '0;
                        pend_q    <= 1'b0;
                        done_q    <= 1'b0;
                        error_q   <= 1'b0;
                        err_idx_q <= '0;
                        busy_q    <= 1'b1;
                    end else if (start_i) begin
                        pend_q <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
